dma_uart_rx: RTL and testbench

Receive-side companion to `dma_uart`: deserialises the host's read-response stream on `uart_rxd` (8N1, LSB first, same bit rate as the transmit side) and reassembles each 3-byte response into one 18-bit DMA word. It sits between the board UART RX pin and the DMA read-data consumer. It emits a one-cycle valid pulse per word and a one-cycle error pulse per discarded word.

---
 rtl/dma_uart_pkg.sv | 17 +
 rtl/uart_rx_byte.sv | 119 +++++++++++
 rtl/dma_uart_rx.sv | 98 +++++++++
 tb/tb_dma_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_uart_pkg.sv
// Shared definitions for the dma_uart transmit/receive pair.
package dma_uart_pkg;

  localparam int DEFAULT_CYCLES_PER_BIT = 5208;
  localparam int DMA_DATA_W             = 18;
  localparam int DMA_ADDR_W             = 7;
  localparam int BYTES_PER_WORD         = 3;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, bit-timing counter and byte FSM.
// start_det flags the confirmed start bit (low at mid-bit), so line glitches
// shorter than half a bit never reach the word level.
module uart_rx_byte
  import dma_uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr,
  output logic       rx_idle,
  output logic       start_det
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);

  logic             sync1_q, sync2_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_d, ferr_d;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so sync2_q takes the old sync1_q, giving two real stages.
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
    end
  end

  // State, counters, shift register and registered byte strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_ferr  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      byte_ferr  <= ferr_d;
    end
  end

  // Next-state logic: mid-bit sampling of start, data and stop bits.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    start_det = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            start_det = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;
  assign rx_idle   = (state_q == RX_IDLE);

endmodule

// File: rtl/dma_uart_rx.sv
// Reassembles three received bytes into one 18-bit DMA word, discarding
// words with a framing error, a non-zero pad field or an inter-byte timeout.
module dma_uart_rx
  import dma_uart_pkg::*;
#(
  parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rxd,
  output logic [DMA_DATA_W-1:0] dma_dat_r,
  output logic                  dma_dat_r_valid,
  output logic                  rx_err,
  output logic                  busy
);

  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CYCLES_PER_BIT;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int LOW_W          = 8 * (BYTES_PER_WORD - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [7:0]       byte_data;
  logic             byte_valid, byte_ferr, rx_idle, start_det;
  logic [IDX_W-1:0] idx_q;
  logic [LOW_W-1:0] low_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             to_expired;

  uart_rx_byte #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr),
    .rx_idle   (rx_idle),
    .start_det (start_det)
  );

  assign to_expired = (idx_q != '0) && rx_idle && (to_cnt_q == TO_LIMIT);

  // Inter-byte idle timer: runs only while a partial word waits in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if ((idx_q == '0) || start_det) begin
      to_cnt_q <= '0;
    end else if (rx_idle && (to_cnt_q != TO_LIMIT)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Word assembler: byte index, low bytes, output word and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q           <= '0;
      low_q           <= '0;
      dma_dat_r       <= '0;
      dma_dat_r_valid <= 1'b0;
      rx_err          <= 1'b0;
      busy            <= 1'b0;
    end else begin
      dma_dat_r_valid <= 1'b0;
      rx_err          <= 1'b0;
      if (start_det) busy <= 1'b1;
      if (byte_ferr) begin
        idx_q  <= '0;
        rx_err <= 1'b1;
        busy   <= 1'b0;
      end else if (byte_valid) begin
        if (idx_q == LAST_IDX) begin
          idx_q <= '0;
          busy  <= 1'b0;
          if (byte_data[7:2] == 6'b0) begin
            dma_dat_r       <= {byte_data[1:0], low_q};
            dma_dat_r_valid <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
        end else begin
          if (idx_q == '0) low_q[7:0]  <= byte_data;
          else             low_q[15:8] <= byte_data;
          idx_q <= idx_q + 1'b1;
        end
      end else if (to_expired) begin
        idx_q  <= '0;
        rx_err <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dma_uart_rx.sv
// Scoreboard bench for dma_uart_rx with a shortened bit time.
module tb_dma_uart_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk;
  logic        reset;
  logic        uart_rxd;
  logic [17:0] dma_dat_r;
  logic        dma_dat_r_valid;
  logic        rx_err;
  logic        busy;

  typedef struct {
    bit          is_err;
    logic [17:0] dat;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [17:0] last_good;
  logic        prev_busy;
  int          total = 0;
  int          bad   = 0;

  dma_uart_rx #(
    .CYCLES_PER_BIT(CPB),
    .TIMEOUT_BITS  (TOB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .uart_rxd       (uart_rxd),
    .dma_dat_r      (dma_dat_r),
    .dma_dat_r_valid(dma_dat_r_valid),
    .rx_err         (rx_err),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [17:0] dat);
    exp_t e;
    e.is_err = is_err;
    e.dat    = dat;
    exp_q.push_back(e);
  endtask

  task automatic line_bits(input logic v, input int nbits);
    uart_rxd = v;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    line_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) line_bits(b[i], 1);
    line_bits(stop, 1);
    uart_rxd = 1'b1;
  endtask

  // Reference: word = b0 + 256*b1 + 65536*b2, accepted only when b2 < 4.
  task automatic send_word_bytes(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input int gap);
    int value;
    send_byte(b0, 1'b1);
    line_bits(1'b1, gap);
    send_byte(b1, 1'b1);
    line_bits(1'b1, gap);
    if (b2 < 8'd4) begin
      value     = int'(b0) + 256 * int'(b1) + 65536 * int'(b2);
      last_good = value[17:0];
      push_exp(1'b0, last_good);
    end else begin
      push_exp(1'b1, last_good);
    end
    send_byte(b2, 1'b1);
  endtask

  task automatic send_word(input logic [17:0] w, input int gap);
    send_word_bytes(w[7:0], w[15:8], {6'b0, w[17:16]}, gap);
  endtask

  // Bytes before index k go out cleanly; byte k carries a low stop bit.
  task automatic send_ferr(input int k, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    if (k > 0) send_byte(b0, 1'b1);
    if (k > 1) send_byte(b1, 1'b1);
    push_exp(1'b1, last_good);
    send_byte((k == 0) ? b0 : (k == 1) ? b1 : b2, 1'b0);
    line_bits(1'b1, 2);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && (dma_dat_r_valid || rx_err)) begin
      check("pulse_exclusive", 32'(dma_dat_r_valid & rx_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({dma_dat_r_valid, rx_err}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_err", 32'(rx_err), 32'(mon_e.is_err));
        check("dma_dat_r", 32'(dma_dat_r), 32'(mon_e.dat));
        check("busy_falls", 32'(busy), 32'd0);
        check("busy_before", 32'(prev_busy), 32'd1);
      end
    end
    prev_busy = busy;
  end

  initial begin
    logic        any_busy;
    logic [31:0] r;
    int          waited;

    reset     = 1'b1;
    uart_rxd  = 1'b1;
    last_good = '0;
    prev_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_dat", 32'(dma_dat_r), 32'd0);
    check("reset_pulses", 32'({dma_dat_r_valid, rx_err, busy}), 32'd0);
    reset = 1'b0;
    line_bits(1'b1, 2);

    // Alternating pattern word.
    send_word(18'h2AAAA, 0);
    line_bits(1'b1, 2);

    // Two words back to back with no idle time.
    send_word(18'h00001, 0);
    send_word(18'h3FFFF, 0);
    line_bits(1'b1, 2);

    // Short low glitch must not start a byte.
    any_busy = 1'b0;
    uart_rxd = 1'b0;
    repeat (4) begin @(negedge clk); any_busy |= busy; end
    uart_rxd = 1'b1;
    repeat (3 * CPB) begin @(negedge clk); any_busy |= busy; end
    check("glitch_busy", 32'(any_busy), 32'd0);
    send_word(18'h12345, 0);
    line_bits(1'b1, 2);

    // Framing error on byte 1, then a clean word.
    send_ferr(1, 8'hEF, 8'hBE, 8'h00);
    send_word(18'h0BEEF, 0);
    line_bits(1'b1, 2);

    // Inter-byte timeout after byte 0.
    send_byte(8'h5A, 1'b1);
    push_exp(1'b1, last_good);
    line_bits(1'b1, TOB + 1);
    check("timeout_busy", 32'(busy), 32'd0);
    send_word(18'h2C3A5, 1);
    line_bits(1'b1, 2);

    // Non-zero pad bits in byte 2 discard the word.
    send_word_bytes(8'h34, 8'h12, 8'h07, 0);
    line_bits(1'b1, 2);
    check("pad_err_hold", 32'(dma_dat_r), 32'h2C3A5);

    // Reset in the middle of byte 1's data bits.
    send_byte(8'h11, 1'b1);
    line_bits(1'b1, 1);
    line_bits(1'b0, 1);
    line_bits(1'b1, 1);
    line_bits(1'b0, 1);
    line_bits(1'b1, 1);
    reset    = 1'b1;
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    last_good = '0;
    @(negedge clk);
    check("midreset_dat", 32'(dma_dat_r), 32'd0);
    check("midreset_pulses", 32'({dma_dat_r_valid, rx_err, busy}), 32'd0);
    line_bits(1'b1, 12);
    send_word(18'h1C0DE, 0);
    line_bits(1'b1, 2);

    // Randomised mix of clean words, bad pad bytes and framing errors.
    for (int n = 0; n < 30; n++) begin
      r = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: send_word(r[17:0], $urandom_range(0, 3));
        6, 7:             send_word_bytes(r[7:0], r[15:8], 8'($urandom_range(4, 255)),
                                          $urandom_range(0, 3));
        default:          send_ferr($urandom_range(0, 2), r[7:0], r[15:8], r[23:16]);
      endcase
      line_bits(1'b1, $urandom_range(0, 2));
    end

    line_bits(1'b1, 3);
    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
